// File: rtl/seg7_pkg.sv
// Shared constants and helpers for the multiplexed 7-segment scan driver.
package seg7_pkg;

    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Active-low g..a patterns, index = hex value (entry 15 listed first).
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h18, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    function automatic int unsigned calc_ticks(input int unsigned clk_hz,
                                               input int unsigned scan_hz);
        return clk_hz / scan_hz;
    endfunction

    function automatic int unsigned width_of(input int unsigned n);
        return (n > 1) ? int'($clog2(n)) : 1;
    endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Frame-load bus: per-digit nibbles, decimal points, enables, load strobe and ack.
interface seg7_scan_driver_if #(
    parameter int unsigned NUM_DIGITS = 8
);
    logic [4*NUM_DIGITS-1:0] data_i;
    logic [NUM_DIGITS-1:0]   dp_i;
    logic [NUM_DIGITS-1:0]   en_i;
    logic                    load_i;
    logic                    load_ack_o;

    modport master (
        output data_i, dp_i, en_i, load_i,
        input  load_ack_o
    );

    modport slave (
        input  data_i, dp_i, en_i, load_i,
        output load_ack_o
    );
endinterface

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low g..a segment pattern.
module hex_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    assign seg_o = SEG_TABLE[nibble_i];

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode 7-segment driver with frame-synchronous loading.
// Define SEG7_LZ_BLANK_EN to compile in leading-zero blanking.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int unsigned NUM_DIGITS   = 8,
    parameter int unsigned CLK_HZ       = 100_000_000,
    parameter int unsigned SCAN_HZ      = 1000,
    parameter int unsigned BLANK_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    seg7_scan_driver_if.slave     bus,
    output logic [7:0]            SEG,
    output logic [NUM_DIGITS-1:0] AN
);

    localparam int unsigned TICKS = calc_ticks(CLK_HZ, SCAN_HZ);
    localparam int unsigned CNT_W = width_of(TICKS);
    localparam int unsigned IDX_W = width_of(NUM_DIGITS);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TICKS - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

    if (BLANK_CYCLES >= TICKS) begin : g_bad_blank
        $error("seg7_scan_driver: BLANK_CYCLES must be smaller than CLK_HZ/SCAN_HZ");
    end
    if (NUM_DIGITS < 1 || NUM_DIGITS > 16) begin : g_bad_digits
        $error("seg7_scan_driver: NUM_DIGITS must be in 1..16");
    end

    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic [IDX_W-1:0]            idx_q, idx_d;
    logic [NUM_DIGITS-1:0][3:0]  stg_data_q, stg_data_d;
    logic [NUM_DIGITS-1:0]       stg_dp_q, stg_dp_d;
    logic [NUM_DIGITS-1:0]       stg_en_q, stg_en_d;
    logic                        pending_q, pending_d;
    logic [NUM_DIGITS-1:0][3:0]  shd_data_q, shd_data_d;
    logic [NUM_DIGITS-1:0]       shd_dp_q, shd_dp_d;
    logic [NUM_DIGITS-1:0]       shd_en_q, shd_en_d;
    logic [7:0]                  seg_q, seg_d;
    logic [NUM_DIGITS-1:0]       an_q, an_d;

    logic                        boundary_c;
    logic                        commit_c;
    logic                        lit_c;
    logic [3:0]                  cur_nib_c;
    logic [6:0]                  cur_pat_c;
    logic [NUM_DIGITS-1:0]       lz_blank_c;
    logic [NUM_DIGITS-1:0][3:0]  in_data_c;

    assign in_data_c      = bus.data_i;
    assign boundary_c     = (cnt_q == CNT_LAST) && (idx_q == IDX_LAST);
    assign commit_c       = boundary_c && (pending_q || bus.load_i);
    assign bus.load_ack_o = commit_c;
    assign SEG            = seg_q;
    assign AN             = an_q;

    // Slot counter and digit index.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        idx_d = idx_q;
        if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end
    end

    // Staging captures every load; shadow only changes at a frame boundary.
    always_comb begin
        stg_data_d = stg_data_q;
        stg_dp_d   = stg_dp_q;
        stg_en_d   = stg_en_q;
        pending_d  = pending_q;
        shd_data_d = shd_data_q;
        shd_dp_d   = shd_dp_q;
        shd_en_d   = shd_en_q;
        if (bus.load_i) begin
            stg_data_d = in_data_c;
            stg_dp_d   = bus.dp_i;
            stg_en_d   = bus.en_i;
            pending_d  = 1'b1;
        end
        if (commit_c) begin
            pending_d = 1'b0;
            if (bus.load_i) begin
                shd_data_d = in_data_c;
                shd_dp_d   = bus.dp_i;
                shd_en_d   = bus.en_i;
            end else begin
                shd_data_d = stg_data_q;
                shd_dp_d   = stg_dp_q;
                shd_en_d   = stg_en_q;
            end
        end
    end

`ifdef SEG7_LZ_BLANK_EN
    // Blank zeros from the top down until the first shown enabled digit; digit 0 always shown.
    always_comb begin
        logic above_zero;
        above_zero = 1'b1;
        lz_blank_c = '0;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            if (shd_en_q[IDX_W'(k)]) begin
                if (above_zero && (shd_data_q[IDX_W'(k)] == 4'h0) && !shd_dp_q[IDX_W'(k)]) begin
                    lz_blank_c[IDX_W'(k)] = 1'b1;
                end else begin
                    above_zero = 1'b0;
                end
            end
        end
    end
`else
    assign lz_blank_c = '0;
`endif

    assign cur_nib_c = shd_data_q[idx_q];

    hex_to_seg7 u_dec (
        .nibble_i (cur_nib_c),
        .seg_o    (cur_pat_c)
    );

    // Next output state: blank gap at slot start, then the selected digit if shown.
    always_comb begin
        seg_d = SEG_BLANK;
        an_d  = '1;
        lit_c = (cnt_q >= CNT_BLANK) && shd_en_q[idx_q] && !lz_blank_c[idx_q];
        if (lit_c) begin
            seg_d        = {~shd_dp_q[idx_q], cur_pat_c};
            an_d[idx_q]  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            idx_q      <= '0;
            stg_data_q <= '0;
            stg_dp_q   <= '0;
            stg_en_q   <= '0;
            pending_q  <= 1'b0;
            shd_data_q <= '0;
            shd_dp_q   <= '0;
            shd_en_q   <= '0;
            seg_q      <= SEG_BLANK;
            an_q       <= '1;
        end else begin
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            stg_data_q <= stg_data_d;
            stg_dp_q   <= stg_dp_d;
            stg_en_q   <= stg_en_d;
            pending_q  <= pending_d;
            shd_data_q <= shd_data_d;
            shd_dp_q   <= shd_dp_d;
            shd_en_q   <= shd_en_d;
            seg_q      <= seg_d;
            an_q       <= an_d;
        end
    end

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Time-multiplexed driver for a bank of common-anode 7-segment digits. It holds a frame of NUM_DIGITS hex nibbles plus per-digit decimal-point and enable bits, and scans one digit at a time at a fixed refresh rate. Between digits it inserts a blanking gap to suppress ghosting. New frames are loaded through a strobe/acknowledge pair and applied only at frame boundaries, so a frame is never displayed half-old, half-new. It sits between board switch/logic sources and the SEG/AN pins, replacing static one-digit decode.

## Interface
- NUM_DIGITS, 8, number of digits scanned (1..16)
- CLK_HZ, 100_000_000, clk frequency in Hz
- SCAN_HZ, 1000, per-digit slot rate; TICKS = CLK_HZ/SCAN_HZ cycles per slot
- BLANK_CYCLES, 16, blanked cycles at the start of each slot; must satisfy BLANK_CYCLES < TICKS (elaboration error otherwise)
- clk  in  1  system clock; single clock domain
- rst_n  in  1  asynchronous, active-low reset
- data_i  in  4*NUM_DIGITS  hex nibble per digit; digit k = data_i[4k+3:4k], digit 0 rightmost
- dp_i  in  NUM_DIGITS  decimal point per digit, 1 = lit
- en_i  in  NUM_DIGITS  digit enable, 1 = shown
- load_i  in  1  strobe: capture data_i/dp_i/en_i into staging
- load_ack_o  out  1  one-cycle pulse when a staged frame becomes the displayed frame
- SEG  out  8  segments, active low; SEG[7] = DP, SEG[6:0] = g..a
- AN  out  NUM_DIGITS  digit selects, active low

## Operation
- Slot counter cnt runs 0..TICKS-1. At TICKS-1 it wraps to 0 and the digit index idx advances; idx wraps NUM_DIGITS-1 -> 0.
- Frame boundary: the cycle where cnt = TICKS-1 and idx = NUM_DIGITS-1.
- Registers:
  - staging: data/dp/en plus a pending flag.
  - shadow: the frame currently displayed.
- Load handling:
  - load_i high captures the inputs into staging and sets pending. A later load_i overwrites staging; last one wins.
  - At a frame boundary with pending set, shadow <= staging, pending clears, and load_ack_o pulses.
  - If load_i is high on the boundary cycle itself, the inputs of that cycle go directly to shadow and the ack pulses.
- Display of digit idx:
  - While cnt < BLANK_CYCLES, the digit is blanked: AN all ones, SEG = 8'hFF.
  - Otherwise, if shadow en[idx] is set: AN[idx] = 0 and SEG = {~dp[idx], decode(nibble[idx])}.
  - Otherwise the digit stays blanked.
- Decode values (active low, 7 bits), 0..F in order: 40 79 24 30 19 12 02 78 00 18 08 03 46 21 06 0E (hex).

## Timing
- SEG and AN are registered: each shows the state computed from the previous cycle's cnt/idx/shadow (1-cycle latency).
- Reset values:
  - SEG = 8'hFF, AN = all ones, load_ack_o = 0.
  - cnt = 0, idx = 0.
  - shadow and staging all zero, so all digits are disabled and the display is blank; pending = 0.
- Assertion of rst_n mid-frame forces the reset values immediately. It discards pending and staging; no ack is issued.
- First enabled digit lights BLANK_CYCLES+1 cycles after reset release, and only after a load has been applied at a boundary.
- Full frame period = NUM_DIGITS*TICKS cycles. Worst-case load-to-ack latency = that period. Best case = 0 cycles (load on the boundary cycle).
- With NUM_DIGITS = 1, every slot end is a frame boundary.

## Configuration
- SEG7_LZ_BLANK_EN defined: leading-zero blanking is compiled in.
  - Scanning from digit NUM_DIGITS-1 downward, each enabled digit with nibble 0 and dp 0 is blanked while all enabled digits above it are also blanked zeros.
  - Digit 0 is never blanked by this rule.
  - The decision is recomputed from shadow only, so it changes only at frame boundaries.
- SEG7_LZ_BLANK_EN undefined: every enabled digit is shown, including leading zeros.

## Structure
- Package seg7_pkg:
  - the 16-entry active-low segment constant table;
  - SEG_BLANK = 8'hFF;
  - a function computing TICKS from CLK_HZ/SCAN_HZ.
- Sub-module hex_to_seg7: purely combinational nibble -> 7-bit pattern lookup using the package table.
- Everything else (counters, staging/shadow registers, blanking mask, output registers) lives in the top module.

## Test plan
- Sim parameters: NUM_DIGITS=4, CLK_HZ=1000, SCAN_HZ=100 (TICKS=10), BLANK_CYCLES=2.
- Reset, no load -> AN=4'hF, SEG=8'hFF for 200 cycles; load_ack_o never high.
- Load data_i=16'h1234, en_i=4'hF, dp_i=0 mid-frame -> ack at next boundary. Each following slot: 2 blank cycles, then 8 cycles with AN low on one digit (digit 0 shows 0x19 for "4", digit 3 shows 0x79 for "1"), SEG[7]=1.
- Two loads (16'hAAAA then 16'h5555) before one boundary -> single ack; the display shows 5555 (0x12 on all digits).
- load_i asserted exactly on the boundary cycle with 16'h00F0 -> ack in that cycle; the next frame shows the new data. With SEG7_LZ_BLANK_EN, digit 3 is blanked and digit 0 shows 0x40; without the macro, digit 3 shows 0x40.
- en_i=4'b0101, dp_i=4'b0001 -> AN[1] and AN[3] never low; SEG[7]=0 only during digit 0's lit cycles.
- rst_n low for 1 cycle while a load is pending -> outputs return to reset values at once and no ack follows.
